// File: rtl/square_calculator.sv
// -----------------------------------------------------------------------------
// square_calculator
//
// Iterative unsigned squarer. The IN_WIDTH-bit root is multiplied by itself
// with a shift-add loop that consumes one multiplier bit per clock, so each
// operation takes exactly IN_WIDTH cycles in CALC and does not depend on the
// data. The 2*IN_WIDTH-bit result is meant to feed sqrt_calculator. error
// flags results with the MSB set, which sqrt_calculator treats as negative.
//
// Ports:
//   clk    in   1            system clock, all state on the rising edge
//   rst    in   1            synchronous active-high reset, wins over start
//   start  in   1            request, accepted only in IDLE or DONE
//   in     in   IN_WIDTH     unsigned root, captured on the accepting edge
//   out    out  2*IN_WIDTH   unsigned square in*in
//   error  out  1            out[MSB] of the last result
//   done   out  1            result valid, held until next accept or reset
//   busy   out  1            high while the shift-add loop runs (CALC)
// -----------------------------------------------------------------------------
module square_calculator #(
   parameter int IN_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_WIDTH-1:0]   in,
   output logic [2*IN_WIDTH-1:0] out,
   output logic                  error,
   output logic                  done,
   output logic                  busy
);

   localparam int OUT_W = 2 * IN_WIDTH;
   localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 accept;
   logic                 last_iter;
   logic [OUT_W-1:0]     acc;
   logic [OUT_W-1:0]     mcand;
   logic [OUT_W-1:0]     acc_sum;
   logic [IN_WIDTH-1:0]  mplier;
   logic [CNT_W-1:0]     cnt;

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier bit is set. The sum wraps at OUT_W bits, which never loses
   // information because the square of an IN_WIDTH-bit value fits in OUT_W.
   function automatic logic [OUT_W-1:0] shift_add_step(
      input logic [OUT_W-1:0] acc_in,
      input logic [OUT_W-1:0] addend,
      input logic             take
   );
      logic [OUT_W-1:0] sum;
      sum = acc_in + addend;
      return take ? sum : acc_in;
   endfunction

   assign acc_sum = shift_add_step(acc, mcand, mplier[0]);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and status outputs. done and busy come straight from the
   // state so they can never disagree with it.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last_iter  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            // cnt counts completed iterations; when it equals IN_WIDTH-1 the
            // step happening on this edge is the last one.
            if (cnt == LAST_CNT) begin
               last_iter  = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture, shift-add iteration and result landing.
   // out/error only change on the final iteration, so they hold the previous
   // result through a new operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         out    <= '0;
         error  <= 1'b0;
      end else if (accept) begin
         acc    <= '0;
         mcand  <= {{IN_WIDTH{1'b0}}, in};
         mplier <= in;
         cnt    <= '0;
      end else if (state == CALC) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (last_iter) begin
            out   <= acc_sum;
            error <= acc_sum[OUT_W-1];
         end
      end
   end

endmodule

// File: tb/tb_square_calculator.sv
// -----------------------------------------------------------------------------
// tb_square_calculator
//
// Self-checking bench for square_calculator (IN_WIDTH = 8). Expected squares,
// error flags and latencies come from plain integer arithmetic on the root.
// -----------------------------------------------------------------------------
module tb_square_calculator;

   localparam int W     = 8;
   localparam int OW    = 2 * W;
   localparam int LIMIT = 40;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  root;
   logic [OW-1:0] sq;
   logic          error;
   logic          done;
   logic          busy;

   int n_vec;
   int n_err;

   square_calculator #(.IN_WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in    (root),
      .out   (sq),
      .error (error),
      .done  (done),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start an operation and wait (bounded) for done. lat is the number of
   // edges after the accepting edge until done is seen.
   task automatic do_op(input logic [W-1:0] v, output int lat);
      root  = v;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 0;
      while (!done && lat < LIMIT) begin
         tick();
         lat++;
      end
   endtask

   // Integer square root, standing in for sqrt_calculator.
   function automatic int isqrt(input int v);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   function automatic logic model_err(input int sqv);
      return sqv >= (1 << (OW - 1));
   endfunction

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      root  = '0;
      tick();
      rst = 1'b0;
      for (int i = 0; i <= 20; i++) begin
         n_vec++;
         if ({sq, error, done, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_idle cycle %0d: out=%0d error=%b done=%b busy=%b expected all 0",
                     i, sq, error, done, busy);
         end
         tick();
      end
   endtask

   task automatic test_basic();
      int busy_cycles;
      int lat;
      root  = 8'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < LIMIT && !done; i++) begin
         if (busy) busy_cycles++;
         tick();
      end
      n_vec++;
      if (busy_cycles !== W) begin
         n_err++;
         $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cycles, W);
      end
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || sq !== 16'd16 || error !== 1'b0) begin
         n_err++;
         $display("FAIL basic_4: done=%b busy=%b out=%0d error=%b expected 1 0 16 0",
                  done, busy, sq, error);
      end
      do_op(8'd5, lat);
      n_vec++;
      if (sq !== 16'd25 || error !== 1'b0 || lat !== W) begin
         n_err++;
         $display("FAIL basic_5: out=%0d error=%b lat=%0d expected 25 0 %0d", sq, error, lat, W);
      end
   endtask

   task automatic test_boundaries();
      int vals [4]  = '{0, 181, 182, 255};
      int squs [4]  = '{0, 32761, 33124, 65025};
      int errs [4]  = '{0, 0, 1, 1};
      int lat;
      for (int i = 0; i < 4; i++) begin
         do_op(W'(vals[i]), lat);
         n_vec++;
         if (sq !== OW'(squs[i]) || error !== errs[i][0] || lat !== W) begin
            n_err++;
            $display("FAIL boundary_%0d: out=%0d error=%b lat=%0d expected %0d %0d %0d",
                     vals[i], sq, error, lat, squs[i], errs[i], W);
         end
      end
   endtask

   task automatic test_ignored_start();
      int lat;
      root  = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      root  = 8'd9;
      tick();
      start = 1'b0;
      root  = W'($urandom);
      lat   = 3;
      while (!done && lat < LIMIT) begin
         tick();
         lat++;
      end
      n_vec++;
      if (sq !== 16'd9 || lat !== W) begin
         n_err++;
         $display("FAIL ignored_start: out=%0d lat=%0d expected 9 %0d", sq, lat, W);
      end
      // restart from DONE with no idle cycle
      root  = 8'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b1 || sq !== 16'd9) begin
         n_err++;
         $display("FAIL restart_from_done: done=%b busy=%b out=%0d expected 0 1 9", done, busy, sq);
      end
      for (int i = 1; i < W; i++) begin
         tick();
         n_vec++;
         if (sq !== 16'd9 || done !== 1'b0) begin
            n_err++;
            $display("FAIL out_hold cycle %0d: out=%0d done=%b expected 9 0", i, sq, done);
         end
      end
      tick();
      n_vec++;
      if (done !== 1'b1 || sq !== 16'd81 || error !== 1'b0) begin
         n_err++;
         $display("FAIL restart_result: done=%b out=%0d error=%b expected 1 81 0", done, sq, error);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      root  = 8'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({sq, error, done, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_mid: out=%0d error=%b done=%b busy=%b expected all 0",
                  sq, error, done, busy);
      end
      for (int i = 0; i < 12; i++) tick();
      n_vec++;
      if ({sq, error, done, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_abort_stays_idle: out=%0d error=%b done=%b busy=%b expected all 0",
                  sq, error, done, busy);
      end
      do_op(8'd13, lat);
      n_vec++;
      if (sq !== 16'd169 || error !== 1'b0 || lat !== W) begin
         n_err++;
         $display("FAIL after_reset_13: out=%0d error=%b lat=%0d expected 169 0 %0d", sq, error, lat, W);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      root  = 8'd10;
      start = 1'b1;
      tick();
      lat = 0;
      while (!done && lat < LIMIT) begin
         tick();
         lat++;
      end
      n_vec++;
      if (sq !== 16'd100 || lat !== W) begin
         n_err++;
         $display("FAIL b2b_first: out=%0d lat=%0d expected 100 %0d", sq, lat, W);
      end
      root = 8'd20;
      tick();
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_reaccept: done=%b busy=%b expected 0 1", done, busy);
      end
      lat = 0;
      while (!done && lat < LIMIT) begin
         tick();
         lat++;
      end
      start = 1'b0;
      n_vec++;
      if (sq !== 16'd400 || lat !== W) begin
         n_err++;
         $display("FAIL b2b_second: out=%0d lat=%0d expected 400 %0d", sq, lat, W);
      end
   endtask

   task automatic test_round_trip();
      int vals [5] = '{0, 4, 5, 16, 181};
      int lat;
      int r;
      for (int i = 0; i < 5; i++) begin
         do_op(W'(vals[i]), lat);
         r = isqrt(int'(sq));
         n_vec++;
         if (r !== vals[i] || sq[OW-1] !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL round_trip_%0d: sqrt(out)=%0d out=%0d error=%b expected %0d with error 0",
                     vals[i], r, sq, error, vals[i]);
         end
      end
      do_op(8'd200, lat);
      n_vec++;
      if (sq !== 16'd40000 || error !== 1'b1 || sq[OW-1] !== 1'b1) begin
         n_err++;
         $display("FAIL round_trip_200: out=%0d error=%b expected 40000 1", sq, error);
      end
   endtask

   task automatic test_random();
      int v;
      int exp_sq;
      int lat;
      for (int i = 0; i < 40; i++) begin
         v      = int'($urandom_range(0, (1 << W) - 1));
         exp_sq = v * v;
         do_op(W'(v), lat);
         n_vec++;
         if (sq !== OW'(exp_sq) || error !== model_err(exp_sq) || lat !== W) begin
            n_err++;
            $display("FAIL random_%0d in=%0d: out=%0d error=%b lat=%0d expected %0d %b %0d",
                     i, v, sq, error, lat, exp_sq, model_err(exp_sq), W);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      start = 1'b0;
      root  = '0;
      test_reset();
      test_basic();
      test_boundaries();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      test_round_trip();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
